dp_fifo_ctrl: RTL
=================

Name: dp_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of the dual_port RAM and drives its write and read ports. It turns a push/pop interface into RAM write-address, read-address and enable signals. It also tracks occupancy and raises full, empty, threshold and error flags. Read data comes back from the RAM and is re-presented with a valid strobe.

Parameters:
WIDTH, 8, data word width; must match dual_port WIDTH
DEPTH, 512, number of entries; must equal 2**ADD_WIDTH
ADD_WIDTH, 9, RAM address width
AF_THRESH, 500, almost_full asserts when count >= AF_THRESH
AE_THRESH, 12, almost_empty asserts when count <= AE_THRESH

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
push  in  1  request to write din this cycle
din  in  WIDTH  push data
pop  in  1  request to read the oldest entry this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADD_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; push attempted while full
underflow  out  1  sticky; pop attempted while empty
wr_en  out  1  RAM write enable
wr_addr  out  ADD_WIDTH  RAM write address
wdata  out  WIDTH  RAM write data
rd_en  out  1  RAM read enable
rd_addr  out  ADD_WIDTH  RAM read address
rdata  in  WIDTH  RAM read data, valid one cycle after rd_en
dout  out  WIDTH  popped data
dout_valid  out  1  dout is valid this cycle

Behaviour:
- Reset:
  - rst is synchronous and active-high.
  - On the rst edge: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout_valid=0.
  - RAM contents are not cleared.
- Pointers:
  - wptr and rptr are ADD_WIDTH+1 bits; the MSB is the wrap bit.
  - wr_addr = wptr[ADD_WIDTH-1:0] and rd_addr = rptr[ADD_WIDTH-1:0].
  - Each pointer increments by 1 on an accepted operation and wraps from DEPTH-1 to 0, toggling the MSB.
- Acceptance (combinational, using registered flags):
  - wr_en = push & ~full; wdata = din.
  - rd_en = pop & ~empty.
  - The write lands in the RAM on the same edge the push is accepted.
- Read latency:
  - dout_valid is rd_en registered, so it is high exactly 1 cycle after an accepted pop.
  - dout = rdata, passed through.
  - There is no fall-through: a push and a pop in the same cycle on an empty FIFO accept the push and reject the pop.
- Count: next count = count + wr_en − rd_en.
  - full, empty, almost_full and almost_empty are registered and derived from next count, so they are valid the cycle after the update.
- Simultaneous push and pop:
  - Not empty and not full: both accepted, count unchanged.
  - Full: pop accepted, push rejected, overflow set.
  - Empty: push accepted, pop rejected, underflow set.
- Error flags: overflow and underflow are sticky until rst. A rejected operation changes no pointer or count.
- Reset during operation: reset has priority over push and pop in the same cycle. A pop accepted in the cycle before rst produces no dout_valid after reset.
- Rejected-operation RAM behaviour: wr_en is 0 for every rejected push and rd_en is 0 for every rejected pop, so the RAM is never written or read on a rejected cycle.

Decomposition:
- Shared package dp_fifo_pkg holds:
  - default WIDTH, DEPTH and ADD_WIDTH constants, shared with the dual_port instance;
  - a function that computes ptr_to_addr;
  - an elaboration check that DEPTH == 2**ADD_WIDTH and AE_THRESH < AF_THRESH <= DEPTH.
- One sub-module, fifo_ptr: an ADD_WIDTH+1 bit wrapping counter with inc and rst inputs, instantiated twice (write pointer and read pointer).
- The top level instantiates no RAM; the integrator wires it to dual_port by name.

Test Plan:
- Fill: after rst, 512 consecutive pushes of din=i[7:0] → full=1 and count=512 after the 512th; a 513th push → wr_en=0, overflow=1, count stays 512.
- Drain and order: from full, 512 consecutive pops → dout_valid each cycle one cycle after each pop, dout sequence 0x00..0xFF twice, then empty=1, count=0.
- Underflow: pop with empty=1 → rd_en=0, dout_valid=0 next cycle, underflow=1, count=0.
- Simultaneous push and pop: at count=5, push and pop together for 10 cycles → count stays 5, data order preserved. At count=0, the same stimulus → count becomes 1 and underflow=1.
- Wrap and thresholds:
  - interleave 600 pushes and 600 pops with occupancy held near 20 → wr_addr and rd_addr wrap 511→0, data is intact;
  - almost_full toggles at count 500; almost_empty toggles at count 12.
- Reset during operation: assert rst in the cycle after a pop at count=7 → dout_valid=0, count=0, empty=1, overflow and underflow cleared; the next push is written to wr_addr=0.

Source files
------------

// File: rtl/dp_fifo_pkg.sv
// Shared constants and helpers for the dual-port FIFO controller.
// Defaults match the dual_port RAM instance the controller drives.
package dp_fifo_pkg;

    localparam int FIFO_WIDTH     = 8;
    localparam int FIFO_DEPTH     = 512;
    localparam int FIFO_ADD_WIDTH = 9;
    localparam int FIFO_AF_THRESH = 500;
    localparam int FIFO_AE_THRESH = 12;

    // Drop the wrap bit: keep the low aw bits of a pointer.
    function automatic logic [31:0] ptr_to_addr(
        input logic [31:0] ptr,
        input int          aw
    );
        return ptr & ((32'd1 << aw) - 32'd1);
    endfunction

    // Geometry and threshold sanity check used at elaboration.
    function automatic bit cfg_ok(
        input int depth,
        input int aw,
        input int af,
        input int ae
    );
        return (depth == (1 << aw)) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer; the MSB is the wrap bit.
// Ports: clk, rst (sync high), inc, ptr[W-1:0].
module fifo_ptr #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/dp_fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual_port RAM.
// Ports: push/din/pop in; flags, count, RAM wr/rd port, dout out.
module dp_fifo_ctrl
    import dp_fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int ADD_WIDTH = FIFO_ADD_WIDTH,
    parameter int AF_THRESH = FIFO_AF_THRESH,
    parameter int AE_THRESH = FIFO_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADD_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 wr_en,
    output logic [ADD_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]     wdata,
    output logic                 rd_en,
    output logic [ADD_WIDTH-1:0] rd_addr,
    input  logic [WIDTH-1:0]     rdata,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid
);

    localparam int CW = ADD_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (!cfg_ok(DEPTH, ADD_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
        $error("dp_fifo_ctrl: bad DEPTH/ADD_WIDTH/threshold set");
    end

    logic [CW-1:0] w_wptr;
    logic [CW-1:0] w_rptr;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [CW-1:0] w_cnt_nxt;

    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_af;
    logic          r_ae;
    logic          r_ovf;
    logic          r_udf;
    logic          r_dv;

    // Acceptance uses registered flags, so empty blocks a same-cycle
    // pop even when a push lands: no fall-through.
    assign w_wr_en = push & ~r_full;
    assign w_rd_en = pop & ~r_empty;

    assign w_cnt_nxt = r_count + CW'(w_wr_en) - CW'(w_rd_en);

    fifo_ptr #(.W(CW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_en),
        .ptr (w_wptr)
    );

    fifo_ptr #(.W(CW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (w_rd_en),
        .ptr (w_rptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_dv    <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == DEPTH_C);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= AF_C);
            r_ae    <= (w_cnt_nxt <= AE_C);
            r_ovf   <= r_ovf | (push & r_full);
            r_udf   <= r_udf | (pop & r_empty);
            r_dv    <= w_rd_en;
        end
    end

    assign wr_en        = w_wr_en;
    assign rd_en        = w_rd_en;
    assign wdata        = din;
    assign wr_addr      = ADD_WIDTH'(ptr_to_addr(32'(w_wptr), ADD_WIDTH));
    assign rd_addr      = ADD_WIDTH'(ptr_to_addr(32'(w_rptr), ADD_WIDTH));
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
    assign dout         = rdata;
    assign dout_valid   = r_dv;

endmodule
